// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - PS/2 host-to-device command byte transmitter
module ps2_host_tx #(
    parameter int INHIBIT_CYC = 10000,
    parameter int RTS_CYC     = 2000,
    parameter int TIMEOUT_CYC = 1500000,
    parameter int FILTER_CYC  = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_err,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe
);

    localparam int MAX_A = (INHIBIT_CYC > RTS_CYC) ? INHIBIT_CYC : RTS_CYC;
    localparam int MAX_C = (MAX_A > TIMEOUT_CYC) ? MAX_A : TIMEOUT_CYC;
    localparam int CW    = $clog2(MAX_C + 1);
    localparam int FW    = $clog2(FILTER_CYC + 1);

    localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYC - 1);
    localparam logic [CW-1:0] RTS_LAST = CW'(RTS_CYC - 1);
    localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_CYC - 1);
    localparam logic [FW-1:0] FLT_LAST = FW'(FILTER_CYC - 1);

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        RTS,
        SEND,
        WAIT_ACK,
        WAIT_REL,
        DONE,
        ERR
    } state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [3:0]    idx, idx_n;
    logic [7:0]    byte_r, byte_n;
    logic          par, par_n;
    logic          doe, doe_n;

    logic [1:0]    clk_sync, data_sync;
    logic          clk_f, clk_f_d;
    logic [FW-1:0] fcnt;
    logic          data_s, fe;

    // Idle bus is high, so the synchronizers and filter reset high to avoid a spurious edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            clk_sync  <= 2'b11;
            data_sync <= 2'b11;
            clk_f     <= 1'b1;
            clk_f_d   <= 1'b1;
            fcnt      <= '0;
        end else begin
            clk_sync  <= {clk_sync[0], ps2_clk_in};
            data_sync <= {data_sync[0], ps2_data_in};
            clk_f_d   <= clk_f;
            if (clk_sync[1] == clk_f) begin
                fcnt <= '0;
            end else if (fcnt == FLT_LAST) begin
                clk_f <= clk_sync[1];
                fcnt  <= '0;
            end else begin
                fcnt <= fcnt + 1'b1;
            end
        end
    end

    assign data_s = data_sync[1];
    assign fe     = clk_f_d & ~clk_f;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            cnt    <= '0;
            idx    <= '0;
            byte_r <= '0;
            par    <= 1'b0;
            doe    <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            idx    <= idx_n;
            byte_r <= byte_n;
            par    <= par_n;
            doe    <= doe_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        idx_n   = idx;
        byte_n  = byte_r;
        par_n   = par;
        doe_n   = doe;
        case (state)
            IDLE: begin
                doe_n = 1'b0;
                cnt_n = '0;
                if (tx_start) begin
                    byte_n  = tx_data;
                    par_n   = ~^tx_data;
                    state_n = INHIBIT;
                end
            end
            INHIBIT: begin
                if (cnt == INH_LAST) begin
                    cnt_n   = '0;
                    doe_n   = 1'b1;
                    state_n = RTS;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            RTS: begin
                doe_n = 1'b1;
                if (cnt == RTS_LAST) begin
                    cnt_n   = '0;
                    idx_n   = '0;
                    state_n = SEND;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            SEND: begin
                // Start bit is already on the bus; each falling edge presents the next bit.
                if (fe) begin
                    cnt_n = '0;
                    idx_n = idx + 4'd1;
                    if (idx < 4'd8) begin
                        doe_n = ~byte_r[idx[2:0]];
                    end else if (idx == 4'd8) begin
                        doe_n = ~par;
                    end else begin
                        doe_n   = 1'b0;
                        state_n = WAIT_ACK;
                    end
                end else if (cnt == TO_LAST) begin
                    state_n = ERR;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            WAIT_ACK: begin
                doe_n = 1'b0;
                if (fe) begin
                    cnt_n   = '0;
                    state_n = data_s ? ERR : WAIT_REL;
                end else if (cnt == TO_LAST) begin
                    state_n = ERR;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            WAIT_REL: begin
                if (clk_f && data_s) begin
                    state_n = DONE;
                end else if (fe) begin
                    cnt_n = '0;
                end else if (cnt == TO_LAST) begin
                    state_n = ERR;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            DONE, ERR: begin
                doe_n   = 1'b0;
                cnt_n   = '0;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    assign ps2_clk_oe  = (state == INHIBIT) || (state == RTS);
    assign ps2_data_oe = doe && ((state == RTS) || (state == SEND));
    assign tx_busy     = (state == INHIBIT) || (state == RTS) || (state == SEND) ||
                         (state == WAIT_ACK) || (state == WAIT_REL);
    assign tx_done     = (state == DONE);
    assign tx_err      = (state == ERR);

endmodule
